// File: rtl/snoop_pkg.sv
// Snoop channel types shared by the snoop arbiter and its route FIFOs.
//   acprot_t  - AC protection attributes (3 bits)
//   acsnoop_t - AC snoop transaction type (4 bits)
//   crresp_t  - CR snoop response (5 bits); bit 0 is DataTransfer
//   cr_has_data() - true when a CR response announces a following CD burst
package snoop_pkg;

    typedef logic [2:0] acprot_t;
    typedef logic [3:0] acsnoop_t;
    typedef logic [4:0] crresp_t;

    localparam int CR_DATA_TRANSFER_BIT = 0;

    function automatic logic cr_has_data(crresp_t resp);
        return resp[CR_DATA_TRANSFER_BIT];
    endfunction

endpackage

// File: rtl/snoop_arb_id_fifo.sv
// Flop-based FIFO of initiator indices used to route in-order snoop
// responses back to the initiator that issued the snoop.
//   clk_i, rst_ni  - clock, asynchronous active-low reset (empties FIFO)
//   push_i, data_i - write an index; ignored while full
//   pop_i          - drop the head entry; ignored while empty
//   full_o, empty_o, head_o - status and oldest stored index
module snoop_arb_id_fifo
    import snoop_pkg::*;
#(
    parameter int Depth = 4,
    parameter int IdxW  = 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push_i,
    input  logic [IdxW-1:0] data_i,
    input  logic            pop_i,
    output logic            full_o,
    output logic            empty_o,
    output logic [IdxW-1:0] head_o
);

    localparam int PtrW = $clog2(Depth);
    localparam logic [PtrW:0] PtrOne = 1;

    // One extra pointer bit distinguishes full from empty when the
    // address bits are equal.
    logic [PtrW:0]   wr_ptr_q, rd_ptr_q;
    logic [IdxW-1:0] mem_q [Depth];
    logic            push_en, pop_en;

    assign full_o  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                     (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign head_o  = mem_q[rd_ptr_q[PtrW-1:0]];

    // A full FIFO refuses the push even if a pop happens the same cycle.
    assign push_en = push_i & ~full_o;
    assign pop_en  = pop_i & ~empty_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
        end else begin
            if (push_en) begin
                mem_q[wr_ptr_q[PtrW-1:0]] <= data_i;
                wr_ptr_q <= wr_ptr_q + PtrOne;
            end
            if (pop_en) rd_ptr_q <= rd_ptr_q + PtrOne;
        end
    end

endmodule

// File: rtl/snoop_arbiter.sv
// Shares one cache snoop port (AC/CR/CD) between NumIn snoop initiators.
// AC requests are round-robin arbitrated onto the cache; CR responses and CD
// bursts come back in order and are steered to the issuing initiator using
// two index FIFOs. All channels are cut-through; only routing state is stored.
//   clk_i, rst_ni            - clock, asynchronous active-low reset
//   in_ac_*                  - per-initiator AC requests (packed NumIn wide)
//   in_cr_*, in_cd_*         - CR/CD back to initiators; payload broadcast,
//                              valid one-hot to the owning initiator
//   out_ac_*, out_cr_*, out_cd_* - single snoop port towards the cache
//   stall_cnt_o              - AC stall cycle counter, present only when
//                              SNOOP_ARB_STALL_CNT_EN is defined
//
// Handshake rule on every channel: a beat transfers in a cycle where valid
// and ready are both high; a raised valid is held with stable payload until
// it transfers, and no valid output depends combinationally on a ready input.
module snoop_arbiter
    import snoop_pkg::*;
#(
    parameter int NumIn     = 2,
    parameter int AddrWidth = 32,
    parameter int DataWidth = 64,
    parameter int MaxTrans  = 4,
    localparam int IdxW     = $clog2(NumIn)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NumIn*AddrWidth-1:0] in_ac_addr_i,
    input  logic [NumIn*3-1:0]         in_ac_prot_i,
    input  logic [NumIn*4-1:0]         in_ac_snoop_i,
    input  logic [NumIn-1:0]           in_ac_valid_i,
    output logic [NumIn-1:0]           in_ac_ready_o,
    output logic [NumIn*5-1:0]         in_cr_resp_o,
    output logic [NumIn-1:0]           in_cr_valid_o,
    input  logic [NumIn-1:0]           in_cr_ready_i,
    output logic [NumIn*DataWidth-1:0] in_cd_data_o,
    output logic [NumIn-1:0]           in_cd_last_o,
    output logic [NumIn-1:0]           in_cd_valid_o,
    input  logic [NumIn-1:0]           in_cd_ready_i,
    output logic [AddrWidth-1:0]       out_ac_addr_o,
    output acprot_t                    out_ac_prot_o,
    output acsnoop_t                   out_ac_snoop_o,
    output logic                       out_ac_valid_o,
    input  logic                       out_ac_ready_i,
    input  crresp_t                    out_cr_resp_i,
    input  logic                       out_cr_valid_i,
    output logic                       out_cr_ready_o,
    input  logic [DataWidth-1:0]       out_cd_data_i,
    input  logic                       out_cd_last_i,
    input  logic                       out_cd_valid_i,
    output logic                       out_cd_ready_o
`ifdef SNOOP_ARB_STALL_CNT_EN
    ,
    output logic [31:0]                stall_cnt_o
`endif
);

    logic [IdxW-1:0] rr_ptr_q, sel_q, rr_sel, sel, rr_next, idx;
    logic            lock_q, found;
    int              j;

    logic            cr_full, cr_empty, cr_push, cr_pop;
    logic [IdxW-1:0] cr_head;
    logic            cd_full, cd_empty, cd_push, cd_pop;
    logic [IdxW-1:0] cd_head;
    logic            need_cd, ac_hs;

    // Round-robin search starting at rr_ptr_q.
    always_comb begin
        rr_sel = rr_ptr_q;
        found  = 1'b0;
        j      = 0;
        idx    = '0;
        for (int i = 0; i < NumIn; i++) begin
            j = int'(rr_ptr_q) + i;
            if (j >= NumIn) j = j - NumIn;
            idx = IdxW'(j);
            if (!found && in_ac_valid_i[idx]) begin
                rr_sel = idx;
                found  = 1'b1;
            end
        end
    end

    // A stalled request keeps its source until it is accepted.
    assign sel     = lock_q ? sel_q : rr_sel;
    assign rr_next = (sel == IdxW'(NumIn - 1)) ? '0 : sel + IdxW'(1);

    assign out_ac_valid_o = (|in_ac_valid_i) & ~cr_full;
    assign out_ac_addr_o  = in_ac_addr_i[sel*AddrWidth +: AddrWidth];
    assign out_ac_prot_o  = in_ac_prot_i[sel*3 +: 3];
    assign out_ac_snoop_o = in_ac_snoop_i[sel*4 +: 4];
    assign ac_hs          = out_ac_valid_o & out_ac_ready_i;

    always_comb begin
        in_ac_ready_o      = '0;
        in_ac_ready_o[sel] = out_ac_ready_i & ~cr_full;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
            sel_q    <= '0;
            lock_q   <= 1'b0;
        end else if (ac_hs) begin
            rr_ptr_q <= rr_next;
            lock_q   <= 1'b0;
        end else if (out_ac_valid_o) begin
            lock_q <= 1'b1;
            sel_q  <= sel;
        end
    end

    // CR routing. A data-carrying response waits until cd_fifo has room
    // so its CD burst can always be routed.
    assign need_cd        = cr_has_data(out_cr_resp_i);
    assign out_cr_ready_o = in_cr_ready_i[cr_head] & ~cr_empty & ~(need_cd & cd_full);
    assign in_cr_resp_o   = {NumIn{out_cr_resp_i}};
    assign cr_push        = ac_hs;
    assign cr_pop         = out_cr_valid_i & out_cr_ready_o;

    always_comb begin
        in_cr_valid_o          = '0;
        in_cr_valid_o[cr_head] = out_cr_valid_i & ~cr_empty;
    end

    // CD routing; the owner entry retires only with the last beat.
    assign out_cd_ready_o = in_cd_ready_i[cd_head] & ~cd_empty;
    assign in_cd_data_o   = {NumIn{out_cd_data_i}};
    assign in_cd_last_o   = {NumIn{out_cd_last_i}};
    assign cd_push        = cr_pop & need_cd;
    assign cd_pop         = out_cd_valid_i & out_cd_ready_o & out_cd_last_i;

    always_comb begin
        in_cd_valid_o          = '0;
        in_cd_valid_o[cd_head] = out_cd_valid_i & ~cd_empty;
    end

    snoop_arb_id_fifo #(.Depth(MaxTrans), .IdxW(IdxW)) cr_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (cr_push),
        .data_i  (sel),
        .pop_i   (cr_pop),
        .full_o  (cr_full),
        .empty_o (cr_empty),
        .head_o  (cr_head)
    );

    snoop_arb_id_fifo #(.Depth(MaxTrans), .IdxW(IdxW)) cd_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (cd_push),
        .data_i  (cr_head),
        .pop_i   (cd_pop),
        .full_o  (cd_full),
        .empty_o (cd_empty),
        .head_o  (cd_head)
    );

`ifdef SNOOP_ARB_STALL_CNT_EN
    logic        stall_inc;
    logic [31:0] stall_cnt_q;

    assign stall_inc   = (out_ac_valid_o & ~out_ac_ready_i) | ((|in_ac_valid_i) & cr_full);
    assign stall_cnt_o = stall_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                                 stall_cnt_q <= '0;
        else if (stall_inc && stall_cnt_q != '1)     stall_cnt_q <= stall_cnt_q + 32'd1;
    end
`else
    // No stall instrumentation in this build.
`endif

endmodule

// File: tb/tb_snoop_arbiter.sv
module tb_snoop_arbiter;

  localparam int NI = 2;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int MT = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NI*AW-1:0] in_ac_addr;
  logic [NI*3-1:0]  in_ac_prot;
  logic [NI*4-1:0]  in_ac_snoop;
  logic [NI-1:0]    in_ac_valid, in_ac_ready;
  logic [NI*5-1:0]  in_cr_resp;
  logic [NI-1:0]    in_cr_valid, in_cr_ready;
  logic [NI*DW-1:0] in_cd_data;
  logic [NI-1:0]    in_cd_last, in_cd_valid, in_cd_ready;
  logic [AW-1:0]    out_ac_addr;
  logic [2:0]       out_ac_prot;
  logic [3:0]       out_ac_snoop;
  logic             out_ac_valid, out_ac_ready;
  logic [4:0]       out_cr_resp;
  logic             out_cr_valid, out_cr_ready;
  logic [DW-1:0]    out_cd_data;
  logic             out_cd_last, out_cd_valid, out_cd_ready;
`ifdef SNOOP_ARB_STALL_CNT_EN
  logic [31:0]      stall_cnt;
`endif

  int tests = 0;
  int fails = 0;

  // per-initiator constant AC attributes: in0 -> prot 2 / snoop 3, in1 -> prot 5 / snoop B
  localparam logic [2:0] PROT0 = 3'd2, PROT1 = 3'd5;
  localparam logic [3:0] SNP0 = 4'h3, SNP1 = 4'hB;

  snoop_arbiter #(.NumIn(NI), .AddrWidth(AW), .DataWidth(DW), .MaxTrans(MT)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .in_ac_addr_i   (in_ac_addr),
    .in_ac_prot_i   (in_ac_prot),
    .in_ac_snoop_i  (in_ac_snoop),
    .in_ac_valid_i  (in_ac_valid),
    .in_ac_ready_o  (in_ac_ready),
    .in_cr_resp_o   (in_cr_resp),
    .in_cr_valid_o  (in_cr_valid),
    .in_cr_ready_i  (in_cr_ready),
    .in_cd_data_o   (in_cd_data),
    .in_cd_last_o   (in_cd_last),
    .in_cd_valid_o  (in_cd_valid),
    .in_cd_ready_i  (in_cd_ready),
    .out_ac_addr_o  (out_ac_addr),
    .out_ac_prot_o  (out_ac_prot),
    .out_ac_snoop_o (out_ac_snoop),
    .out_ac_valid_o (out_ac_valid),
    .out_ac_ready_i (out_ac_ready),
    .out_cr_resp_i  (out_cr_resp),
    .out_cr_valid_i (out_cr_valid),
    .out_cr_ready_o (out_cr_ready),
    .out_cd_data_i  (out_cd_data),
    .out_cd_last_i  (out_cd_last),
    .out_cd_valid_i (out_cd_valid),
    .out_cd_ready_o (out_cd_ready)
`ifdef SNOOP_ARB_STALL_CNT_EN
    ,
    .stall_cnt_o    (stall_cnt)
`endif
  );

  // driver tasks
  task automatic drive_idle();
    in_ac_addr   = '0;
    in_ac_prot   = {PROT1, PROT0};
    in_ac_snoop  = {SNP1, SNP0};
    in_ac_valid  = '0;
    in_cr_ready  = '0;
    in_cd_ready  = '0;
    out_ac_ready = 1'b0;
    out_cr_resp  = '0;
    out_cr_valid = 1'b0;
    out_cd_data  = '0;
    out_cd_last  = 1'b0;
    out_cd_valid = 1'b0;
  endtask

  task automatic drive_ac(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] a1);
    in_ac_valid = v;
    in_ac_addr  = {a1, a0};
  endtask

  task automatic test_reset();
    drive_idle();
    rst_n = 1'b0;
    out_cr_valid = 1'b1;
    out_cd_valid = 1'b1;
    in_cr_ready  = 2'b11;
    in_cd_ready  = 2'b11;
    @(negedge clk); #1;
    tests++;
    if ({out_ac_valid, in_cr_valid, in_cd_valid, out_cr_ready, out_cd_ready} !== 7'b0) begin
      fails++;
      $display("FAIL reset_in: got %b exp 0000000", {out_ac_valid, in_cr_valid, in_cd_valid, out_cr_ready, out_cd_ready});
    end
    @(negedge clk);
    rst_n = 1'b1; #1;
    tests++;
    if ({out_ac_valid, in_cr_valid, in_cd_valid, out_cr_ready, out_cd_ready} !== 7'b0) begin
      fails++;
      $display("FAIL reset_out: got %b exp 0000000", {out_ac_valid, in_cr_valid, in_cd_valid, out_cr_ready, out_cd_ready});
    end
    out_cr_valid = 1'b0;
    out_cd_valid = 1'b0;
    in_cr_ready  = '0;
    in_cd_ready  = '0;
  endtask

  task automatic test_round_robin();
    @(negedge clk);
    drive_ac(2'b11, 32'h1000_0000, 32'h2000_0040);
    out_ac_ready = 1'b1; #1;
    tests++;
    if ({out_ac_valid, in_ac_ready, out_ac_addr, out_ac_prot, out_ac_snoop} !== {1'b1, 2'b01, 32'h1000_0000, PROT0, SNP0}) begin
      fails++;
      $display("FAIL rr_grant0: got %h exp %h", {out_ac_valid, in_ac_ready, out_ac_addr, out_ac_prot, out_ac_snoop}, {1'b1, 2'b01, 32'h1000_0000, PROT0, SNP0});
    end
    @(negedge clk);
    drive_ac(2'b10, 32'h1000_0000, 32'h2000_0040); #1;
    tests++;
    if ({out_ac_valid, in_ac_ready, out_ac_addr, out_ac_prot, out_ac_snoop} !== {1'b1, 2'b10, 32'h2000_0040, PROT1, SNP1}) begin
      fails++;
      $display("FAIL rr_grant1: got %h exp %h", {out_ac_valid, in_ac_ready, out_ac_addr, out_ac_prot, out_ac_snoop}, {1'b1, 2'b10, 32'h2000_0040, PROT1, SNP1});
    end
    // drain: responses come back to in0 then in1, then the queue is empty
    @(negedge clk);
    in_ac_valid  = 2'b00;
    out_cr_valid = 1'b1;
    out_cr_resp  = 5'b00000;
    in_cr_ready  = 2'b11; #1;
    tests++;
    if ({in_cr_valid, out_cr_ready} !== 3'b011) begin
      fails++;
      $display("FAIL rr_cr0: got %b exp 011", {in_cr_valid, out_cr_ready});
    end
    @(negedge clk); #1;
    tests++;
    if ({in_cr_valid, out_cr_ready} !== 3'b101) begin
      fails++;
      $display("FAIL rr_cr1: got %b exp 101", {in_cr_valid, out_cr_ready});
    end
    @(negedge clk); #1;
    tests++;
    if ({in_cr_valid, out_cr_ready} !== 3'b000) begin
      fails++;
      $display("FAIL rr_cr_empty: got %b exp 000", {in_cr_valid, out_cr_ready});
    end
    out_cr_valid = 1'b0;
  endtask

  task automatic test_lock();
    // grant in0 once so the pointer moves to in1
    @(negedge clk);
    drive_ac(2'b01, 32'h3000_0000, 32'h3100_0000);
    out_ac_ready = 1'b1; #1;
    tests++;
    if ({out_ac_valid, in_ac_ready, out_ac_addr} !== {1'b1, 2'b01, 32'h3000_0000}) begin
      fails++;
      $display("FAIL lock_pre: got %h exp %h", {out_ac_valid, in_ac_ready, out_ac_addr}, {1'b1, 2'b01, 32'h3000_0000});
    end
    @(negedge clk);
    drive_ac(2'b01, 32'h3000_0080, 32'h3100_0000);
    out_ac_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) in_ac_valid = 2'b11;
      #1;
      tests++;
      if ({out_ac_valid, in_ac_ready, out_ac_addr, out_ac_prot} !== {1'b1, 2'b00, 32'h3000_0080, PROT0}) begin
        fails++;
        $display("FAIL lock_hold_c%0d: got %h exp %h", c, {out_ac_valid, in_ac_ready, out_ac_addr, out_ac_prot}, {1'b1, 2'b00, 32'h3000_0080, PROT0});
      end
      @(negedge clk);
    end
    out_ac_ready = 1'b1; #1;
    tests++;
    if ({out_ac_valid, in_ac_ready, out_ac_addr} !== {1'b1, 2'b01, 32'h3000_0080}) begin
      fails++;
      $display("FAIL lock_release: got %h exp %h", {out_ac_valid, in_ac_ready, out_ac_addr}, {1'b1, 2'b01, 32'h3000_0080});
    end
    @(negedge clk);
    in_ac_valid = 2'b10; #1;
    tests++;
    if ({out_ac_valid, in_ac_ready, out_ac_addr} !== {1'b1, 2'b10, 32'h3100_0000}) begin
      fails++;
      $display("FAIL lock_next: got %h exp %h", {out_ac_valid, in_ac_ready, out_ac_addr}, {1'b1, 2'b10, 32'h3100_0000});
    end
    // responses in order: in0, in0, in1
    @(negedge clk);
    in_ac_valid  = 2'b00;
    out_cr_valid = 1'b1;
    in_cr_ready  = 2'b11;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests++;
      if ({in_cr_valid, out_cr_ready} !== ((k < 2) ? 3'b011 : 3'b101)) begin
        fails++;
        $display("FAIL lock_cr%0d: got %b exp %b", k, {in_cr_valid, out_cr_ready}, ((k < 2) ? 3'b011 : 3'b101));
      end
      @(negedge clk);
    end
    out_cr_valid = 1'b0; #1;
    tests++;
    if (out_cr_ready !== 1'b0) begin
      fails++;
      $display("FAIL lock_cr_empty: got %b exp 0", out_cr_ready);
    end
  endtask

  task automatic test_full();
    @(negedge clk);
    out_ac_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive_ac(2'b01, 32'h4000_0000 + 32'(k * 64), 32'h0);
      #1;
      tests++;
      if ({out_ac_valid, in_ac_ready, out_ac_addr} !== {1'b1, 2'b01, 32'h4000_0000 + 32'(k * 64)}) begin
        fails++;
        $display("FAIL full_fill%0d: got %h exp %h", k, {out_ac_valid, in_ac_ready, out_ac_addr}, {1'b1, 2'b01, 32'h4000_0000 + 32'(k * 64)});
      end
      @(negedge clk);
    end
    drive_ac(2'b01, 32'h5000_0000, 32'h0); #1;
    tests++;
    if ({out_ac_valid, in_ac_ready} !== 3'b000) begin
      fails++;
      $display("FAIL full_stall0: got %b exp 000", {out_ac_valid, in_ac_ready});
    end
    @(negedge clk);
    out_cr_valid = 1'b1;
    out_cr_resp  = 5'b00000;
    in_cr_ready  = 2'b01; #1;
    tests++;
    if ({out_ac_valid, in_ac_ready, in_cr_valid, out_cr_ready} !== 6'b000_011) begin
      fails++;
      $display("FAIL full_stall1: got %b exp 000011", {out_ac_valid, in_ac_ready, in_cr_valid, out_cr_ready});
    end
    // one slot free: AC push and CR pop in the same cycle
    @(negedge clk); #1;
    tests++;
    if ({out_ac_valid, in_ac_ready, in_cr_valid, out_cr_ready} !== 6'b101_011) begin
      fails++;
      $display("FAIL full_pushpop: got %b exp 101011", {out_ac_valid, in_ac_ready, in_cr_valid, out_cr_ready});
    end
    @(negedge clk);
    in_ac_valid = 2'b00;
    for (int k = 0; k < 4; k++) begin
      #1;
      tests++;
      if ({in_cr_valid, out_cr_ready} !== ((k < 3) ? 3'b011 : 3'b000)) begin
        fails++;
        $display("FAIL full_drain%0d: got %b exp %b", k, {in_cr_valid, out_cr_ready}, ((k < 3) ? 3'b011 : 3'b000));
      end
      @(negedge clk);
    end
    out_cr_valid = 1'b0;
  endtask

  task automatic test_cd_route();
    out_ac_ready = 1'b1;
    drive_ac(2'b10, 32'h0, 32'h6000_0000); #1;
    tests++;
    if ({out_ac_valid, in_ac_ready} !== 3'b110) begin
      fails++;
      $display("FAIL cd_ac1: got %b exp 110", {out_ac_valid, in_ac_ready});
    end
    @(negedge clk);
    drive_ac(2'b01, 32'h6100_0000, 32'h0); #1;
    tests++;
    if ({out_ac_valid, in_ac_ready} !== 3'b101) begin
      fails++;
      $display("FAIL cd_ac0: got %b exp 101", {out_ac_valid, in_ac_ready});
    end
    @(negedge clk);
    in_ac_valid  = 2'b00;
    out_cr_valid = 1'b1;
    out_cr_resp  = 5'b00001;
    in_cr_ready  = 2'b11; #1;
    tests++;
    if ({in_cr_valid, out_cr_ready, in_cr_resp} !== {2'b10, 1'b1, 10'b00001_00001}) begin
      fails++;
      $display("FAIL cd_cr1: got %b exp %b", {in_cr_valid, out_cr_ready, in_cr_resp}, {2'b10, 1'b1, 10'b00001_00001});
    end
    @(negedge clk);
    out_cr_resp = 5'b00000; #1;
    tests++;
    if ({in_cr_valid, out_cr_ready, in_cr_resp} !== {2'b01, 1'b1, 10'b0}) begin
      fails++;
      $display("FAIL cd_cr0: got %b exp %b", {in_cr_valid, out_cr_ready, in_cr_resp}, {2'b01, 1'b1, 10'b0});
    end
    @(negedge clk);
    out_cr_valid = 1'b0;
    out_cd_valid = 1'b1;
    in_cd_ready  = 2'b10;
    for (int b = 0; b < 4; b++) begin
      out_cd_data = 64'hD000_0000_0000_0000 + 64'(b);
      out_cd_last = (b == 3);
      #1;
      tests++;
      if ({in_cd_valid, out_cd_ready, in_cd_last, in_cd_data} !== {2'b10, 1'b1, {2{b == 3}}, {2{64'hD000_0000_0000_0000 + 64'(b)}}}) begin
        fails++;
        $display("FAIL cd_beat%0d: got %h exp %h", b, {in_cd_valid, out_cd_ready, in_cd_last, in_cd_data}, {2'b10, 1'b1, {2{b == 3}}, {2{64'hD000_0000_0000_0000 + 64'(b)}}});
      end
      @(negedge clk);
    end
    out_cd_last = 1'b0; #1;
    tests++;
    if ({in_cd_valid, out_cd_ready} !== 3'b000) begin
      fails++;
      $display("FAIL cd_after_last: got %b exp 000", {in_cd_valid, out_cd_ready});
    end
    out_cd_valid = 1'b0;
    in_cd_ready  = 2'b00;
  endtask

  task automatic test_cd_full();
    @(negedge clk);
    out_ac_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive_ac(2'b10, 32'h0, 32'h7000_0000 + 32'(k));
      #1;
      tests++;
      if ({out_ac_valid, in_ac_ready} !== 3'b110) begin
        fails++;
        $display("FAIL cdf_ac%0d: got %b exp 110", k, {out_ac_valid, in_ac_ready});
      end
      @(negedge clk);
    end
    in_ac_valid  = 2'b00;
    out_cr_valid = 1'b1;
    out_cr_resp  = 5'b00001;
    in_cr_ready  = 2'b10;
    for (int k = 0; k < 4; k++) begin
      #1;
      tests++;
      if ({in_cr_valid, out_cr_ready} !== 3'b101) begin
        fails++;
        $display("FAIL cdf_cr%0d: got %b exp 101", k, {in_cr_valid, out_cr_ready});
      end
      @(negedge clk);
    end
    out_cr_valid = 1'b0;
    drive_ac(2'b01, 32'h7100_0000, 32'h0); #1;
    tests++;
    if ({out_ac_valid, in_ac_ready} !== 3'b101) begin
      fails++;
      $display("FAIL cdf_ac_in0: got %b exp 101", {out_ac_valid, in_ac_ready});
    end
    @(negedge clk);
    in_ac_valid  = 2'b00;
    out_cr_valid = 1'b1;
    out_cr_resp  = 5'b00001;
    in_cr_ready  = 2'b01; #1;
    tests++;
    if ({in_cr_valid, out_cr_ready} !== 3'b010) begin
      fails++;
      $display("FAIL cdf_blocked: got %b exp 010", {in_cr_valid, out_cr_ready});
    end
    out_cr_resp = 5'b00000; #1;
    tests++;
    if (out_cr_ready !== 1'b1) begin
      fails++;
      $display("FAIL cdf_nodata_ok: got %b exp 1", out_cr_ready);
    end
    out_cr_resp = 5'b00001; #1;
    @(negedge clk);
    out_cd_valid = 1'b1;
    out_cd_last  = 1'b0;
    out_cd_data  = 64'h1111;
    in_cd_ready  = 2'b10; #1;
    tests++;
    if ({out_cr_ready, in_cd_valid, out_cd_ready} !== 4'b0101) begin
      fails++;
      $display("FAIL cdf_beat0: got %b exp 0101", {out_cr_ready, in_cd_valid, out_cd_ready});
    end
    @(negedge clk);
    out_cd_last = 1'b1; #1;
    tests++;
    if ({out_cr_ready, in_cd_valid, out_cd_ready} !== 4'b0101) begin
      fails++;
      $display("FAIL cdf_nonlast_kept: got %b exp 0101", {out_cr_ready, in_cd_valid, out_cd_ready});
    end
    @(negedge clk);
    out_cd_valid = 1'b0;
    out_cd_last  = 1'b0; #1;
    tests++;
    if ({in_cr_valid, out_cr_ready} !== 3'b011) begin
      fails++;
      $display("FAIL cdf_unblocked: got %b exp 011", {in_cr_valid, out_cr_ready});
    end
    @(negedge clk);
    out_cr_valid = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    out_cd_valid = 1'b1;
    out_cd_last  = 1'b0;
    in_cd_ready  = 2'b10; #1;
    tests++;
    if ({in_cd_valid, out_cd_ready} !== 3'b101) begin
      fails++;
      $display("FAIL rst_burst_start: got %b exp 101", {in_cd_valid, out_cd_ready});
    end
    @(negedge clk);
    out_cr_valid = 1'b1;
    out_cr_resp  = 5'b00000;
    in_cr_ready  = 2'b11;
    rst_n = 1'b0; #1;
    tests++;
    if ({out_ac_valid, in_cr_valid, in_cd_valid, out_cr_ready, out_cd_ready} !== 7'b0) begin
      fails++;
      $display("FAIL rst_mid_burst: got %b exp 0000000", {out_ac_valid, in_cr_valid, in_cd_valid, out_cr_ready, out_cd_ready});
    end
    @(negedge clk);
    rst_n = 1'b1; #1;
    tests++;
    if ({out_ac_valid, in_cr_valid, in_cd_valid, out_cr_ready, out_cd_ready} !== 7'b0) begin
      fails++;
      $display("FAIL rst_released: got %b exp 0000000", {out_ac_valid, in_cr_valid, in_cd_valid, out_cr_ready, out_cd_ready});
    end
    @(negedge clk);
    out_cr_valid = 1'b0;
    out_cd_valid = 1'b0;
    out_ac_ready = 1'b1;
    drive_ac(2'b11, 32'h8000_0000, 32'h8100_0000); #1;
    tests++;
    if ({out_ac_valid, in_ac_ready, out_ac_addr} !== {1'b1, 2'b01, 32'h8000_0000}) begin
      fails++;
      $display("FAIL rst_rr_ptr: got %h exp %h", {out_ac_valid, in_ac_ready, out_ac_addr}, {1'b1, 2'b01, 32'h8000_0000});
    end
    @(negedge clk);
    in_ac_valid = 2'b10; #1;
    tests++;
    if ({out_ac_valid, in_ac_ready, out_ac_addr} !== {1'b1, 2'b10, 32'h8100_0000}) begin
      fails++;
      $display("FAIL rst_rr_next: got %h exp %h", {out_ac_valid, in_ac_ready, out_ac_addr}, {1'b1, 2'b10, 32'h8100_0000});
    end
    @(negedge clk);
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_lock();
    test_full();
    test_cd_route();
    test_cd_full();
    test_reset_mid_burst();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
